// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: one request channel
// (valid/ready with we/addr/wdata) and the matching one-cycle response.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              valid;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_error;

  // Requester drives the request, observes ready and the response.
  modport master (
    output valid, we, addr, wdata,
    input  ready, rsp_valid, rsp_rdata, rsp_error
  );

  // Arbiter observes the request, drives ready and the response.
  modport slave (
    input  valid, we, addr, wdata,
    output ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data memory.
// Each accepted request is bounds-checked, held on the memory bus for
// ACCESS_LAT cycles and answered with a one-cycle response pulse.
//
// Handshake: a request transfers on a rising edge where valid and ready are
// both 1. The requester holds valid/we/addr/wdata stable until then. ready is
// combinational, only ever high in IDLE, and at most one port sees it per
// cycle. rsp_valid is a single-cycle pulse on the port that owns the access;
// rsp_rdata/rsp_error are meaningful only while rsp_valid is 1.
module dmem_arbiter #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 64,
  parameter int MEM_WORDS  = 1024,
  parameter int ACCESS_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_arbiter_if.slave     req0,
  dmem_arbiter_if.slave     req1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_LAT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_WORDS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              port_q, port_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              gnt0, gnt1, hs;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              addr_err;

  // Grant: only in IDLE and out of reset; a tie goes to the port that was not granted last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n && (state_q == S_IDLE)) begin
      if (req0.valid && (!req1.valid || last_grant_q)) begin
        gnt0 = 1'b1;
      end else if (req1.valid) begin
        gnt1 = 1'b1;
      end
    end
    hs        = gnt0 | gnt1;
    sel_we    = gnt1 ? req1.we    : req0.we;
    sel_addr  = gnt1 ? req1.addr  : req0.addr;
    sel_wdata = gnt1 ? req1.wdata : req0.wdata;
    // Full-width compare so upper address bits can never alias into range.
    addr_err  = (sel_addr >= ADDR_LIMIT);
  end

  // Next-state: capture on handshake, count out the access, then one response cycle.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    port_d       = port_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (hs) begin
          last_grant_d = gnt1;
          port_d       = gnt1;
          we_d         = sel_we;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          err_d        = addr_err;
          rdata_d      = '0;
          cnt_d        = '0;
          state_d      = addr_err ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_RESP;
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and capture registers; reset drops any access in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      port_q       <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      port_q       <= port_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

  // Output decode: memory bus is all-zero outside ACCESS, responses only in RESP.
  always_comb begin
    mem_en          = (state_q == S_ACCESS);
    mem_we          = mem_en & we_q;
    mem_addr        = mem_en ? addr_q  : '0;
    mem_wdata       = mem_en ? wdata_q : '0;
    req0.ready      = gnt0;
    req1.ready      = gnt1;
    req0.rsp_valid  = (state_q == S_RESP) && !port_q;
    req1.rsp_valid  = (state_q == S_RESP) &&  port_q;
    req0.rsp_rdata  = req0.rsp_valid ? rdata_q : '0;
    req1.rsp_rdata  = req1.rsp_valid ? rdata_q : '0;
    req0.rsp_error  = req0.rsp_valid & err_q;
    req1.rsp_error  = req1.rsp_valid & err_q;
    dbg_state       = state_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a word-array memory on the bus side, per-scenario
// tasks on the request side, and an abstract reference model (address map,
// latency and grant order derived from the access rules).
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        mem_en, mem_we;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;

  dmem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) r0 ();
  dmem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) r1 ();

  dmem_arbiter #(.DATA_W(64), .ADDR_W(64), .MEM_WORDS(1024), .ACCESS_LAT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (r0.slave),
    .req1      (r1.slave),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model (bus side) ----------------
  logic [63:0] mem_arr [0:1023];
  always @(posedge clk)
    if (mem_en && mem_we && mem_addr < 64'd1024) mem_arr[mem_addr[9:0]] <= mem_wdata;
  assign mem_rdata = (mem_en && !mem_we && mem_addr < 64'd1024) ? mem_arr[mem_addr[9:0]] : 64'h0;

  // ---------------- reference model / scoreboard ----------------
  logic [63:0] ref_mem [logic [63:0]];
  logic [64:0] exp_q [$];
  int          hs_log [$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_exp_rsp = 0;

  function automatic logic [63:0] ref_read(input logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 64'h0;
  endfunction

  // ---------------- bus monitors ----------------
  int mem_en_cnt = 0;
  int rsp_cnt = 0;
  int viol = 0;
  always @(negedge clk) begin
    if (mem_en) mem_en_cnt++;
    if (r0.rsp_valid) rsp_cnt++;
    if (r1.rsp_valid) rsp_cnt++;
    if (!mem_en && (mem_we || mem_addr != 64'h0 || mem_wdata != 64'h0)) viol++;
    if (r0.ready && r1.ready) viol++;
    if ((r0.ready || r1.ready) && (mem_en || r0.rsp_valid || r1.rsp_valid)) viol++;
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int port, input logic v, input logic we,
                         input logic [63:0] a, input logic [63:0] d);
    if (port == 0) begin
      r0.valid = v; r0.we = we; r0.addr = a; r0.wdata = d;
    end else begin
      r1.valid = v; r1.we = we; r1.addr = a; r1.wdata = d;
    end
  endtask

  // Issues one request and waits for its response; reports latency from the
  // handshake cycle and the number of mem_en cycles seen in between.
  task automatic send(input int port, input logic we, input logic [63:0] a,
                      input logic [63:0] d, output int lat, output logic [63:0] rdata,
                      output logic err, output int men, output logic ok);
    int  hs_cyc;
    int  m0;
    bit  got;
    ok = 1'b0; lat = -1; rdata = 64'h0; err = 1'b0; men = -1;
    hs_cyc = 0; m0 = 0;
    @(negedge clk);
    set_req(port, 1'b1, we, a, d);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      if ((port == 0) ? r0.ready : r1.ready) begin
        got = 1'b1; hs_cyc = cyc; m0 = mem_en_cnt;
        hs_log.push_back(port);
        n_exp_rsp++;
      end
      @(negedge clk);
    end
    set_req(port, 1'b0, 1'b0, 64'h0, 64'h0);
    if (got) begin
      for (int i = 0; i < 20 && !ok; i++) begin
        #1;
        if ((port == 0) ? r0.rsp_valid : r1.rsp_valid) begin
          ok    = 1'b1;
          lat   = cyc - hs_cyc;
          rdata = (port == 0) ? r0.rsp_rdata : r1.rsp_rdata;
          err   = (port == 0) ? r0.rsp_error : r1.rsp_error;
          men   = mem_en_cnt - m0;
        end
        if (!ok) @(negedge clk);
      end
    end
  endtask

  task automatic apply_reset;
    @(negedge clk);
    rst_n = 1'b0;
    set_req(0, 1'b0, 1'b0, 64'h0, 64'h0);
    set_req(1, 1'b0, 1'b0, 64'h0, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    set_req(0, 1'b0, 1'b0, 64'h0, 64'h0);
    set_req(1, 1'b0, 1'b0, 64'h0, 64'h0);
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en got=%b exp=0", mem_en); end
    n_checks++; if ({r0.rsp_valid, r1.rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=00", {r0.rsp_valid, r1.rsp_valid}); end
    n_checks++; if (mem_addr !== 64'h0 || mem_wdata !== 64'h0) begin n_fail++; $display("FAIL reset_mem_bus got=%h/%h exp=0/0", mem_addr, mem_wdata); end
    set_req(0, 1'b1, 1'b0, 64'd1, 64'h0);
    set_req(1, 1'b1, 1'b0, 64'd2, 64'h0);
    #1;
    n_checks++; if ({r0.ready, r1.ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got=%b exp=00", {r0.ready, r1.ready}); end
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 64'h0, 64'h0);
    set_req(1, 1'b0, 1'b0, 64'h0, 64'h0);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read;
    int lat, men; logic [63:0] rd; logic err, ok;
    send(0, 1'b1, 64'd5, 64'hDEAD, lat, rd, err, men, ok);
    ref_mem[64'd5] = 64'hDEAD;
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL wr_timeout got=%b exp=1", ok); end
    n_checks++; if (lat !== 3 || men !== 2) begin n_fail++; $display("FAIL wr_timing got lat=%0d men=%0d exp lat=3 men=2", lat, men); end
    n_checks++; if (rd !== 64'h0 || err !== 1'b0) begin n_fail++; $display("FAIL wr_rsp got rdata=%h err=%b exp 0/0", rd, err); end
    send(0, 1'b0, 64'd5, 64'h0, lat, rd, err, men, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rd_timeout got=%b exp=1", ok); end
    n_checks++; if (lat !== 3 || men !== 2) begin n_fail++; $display("FAIL rd_timing got lat=%0d men=%0d exp lat=3 men=2", lat, men); end
    n_checks++; if (rd !== ref_read(64'd5) || err !== 1'b0) begin n_fail++; $display("FAIL rd_data got rdata=%h err=%b exp %h/0", rd, err, ref_read(64'd5)); end
  endtask

  task automatic test_tie;
    int lat, men; logic [63:0] rd; logic err, ok;
    int l0 [2]; int l1 [2]; int m0 [2]; int m1 [2];
    logic [63:0] d0 [2]; logic [63:0] d1 [2];
    logic e0 [2]; logic e1 [2]; logic k0 [2]; logic k1 [2];
    int exp_order [4];
    send(1, 1'b1, 64'd1, 64'h111, lat, rd, err, men, ok);
    ref_mem[64'd1] = 64'h111;
    send(0, 1'b1, 64'd2, 64'h222, lat, rd, err, men, ok);
    ref_mem[64'd2] = 64'h222;
    apply_reset();
    hs_log.delete();
    fork
      begin
        send(0, 1'b0, 64'd1, 64'h0, l0[0], d0[0], e0[0], m0[0], k0[0]);
        send(0, 1'b0, 64'd1, 64'h0, l0[1], d0[1], e0[1], m0[1], k0[1]);
      end
      begin
        send(1, 1'b0, 64'd2, 64'h0, l1[0], d1[0], e1[0], m1[0], k1[0]);
        send(1, 1'b0, 64'd2, 64'h0, l1[1], d1[1], e1[1], m1[1], k1[1]);
      end
    join
    exp_order = '{0, 1, 0, 1};
    n_checks++; if (hs_log.size() !== 4) begin n_fail++; $display("FAIL tie_count got=%0d exp=4", hs_log.size()); end
    for (int i = 0; i < 4 && i < hs_log.size(); i++) begin
      n_checks++; if (hs_log[i] !== exp_order[i]) begin n_fail++; $display("FAIL tie_order[%0d] got=%0d exp=%0d", i, hs_log[i], exp_order[i]); end
    end
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (k0[i] !== 1'b1 || d0[i] !== ref_read(64'd1) || l0[i] !== 3) begin n_fail++; $display("FAIL tie_p0[%0d] got ok=%b rdata=%h lat=%0d exp 1/%h/3", i, k0[i], d0[i], l0[i], ref_read(64'd1)); end
      n_checks++; if (k1[i] !== 1'b1 || d1[i] !== ref_read(64'd2) || l1[i] !== 3) begin n_fail++; $display("FAIL tie_p1[%0d] got ok=%b rdata=%h lat=%0d exp 1/%h/3", i, k1[i], d1[i], l1[i], ref_read(64'd2)); end
    end
  endtask

  task automatic test_bounds;
    int lat, men; logic [63:0] rd; logic err, ok;
    send(1, 1'b0, 64'd1024, 64'h0, lat, rd, err, men, ok);
    n_checks++; if (ok !== 1'b1 || err !== 1'b1 || rd !== 64'h0) begin n_fail++; $display("FAIL oob_rsp got ok=%b err=%b rdata=%h exp 1/1/0", ok, err, rd); end
    n_checks++; if (lat !== 1 || men !== 0) begin n_fail++; $display("FAIL oob_timing got lat=%0d men=%0d exp lat=1 men=0", lat, men); end
    send(1, 1'b1, 64'd1023, 64'hBEEF, lat, rd, err, men, ok);
    ref_mem[64'd1023] = 64'hBEEF;
    send(1, 1'b0, 64'd1023, 64'h0, lat, rd, err, men, ok);
    n_checks++; if (ok !== 1'b1 || err !== 1'b0 || rd !== ref_read(64'd1023) || lat !== 3) begin n_fail++; $display("FAIL top_word got ok=%b err=%b rdata=%h lat=%0d exp 1/0/%h/3", ok, err, rd, lat, ref_read(64'd1023)); end
    send(0, 1'b0, 64'h1_0000_0005, 64'h0, lat, rd, err, men, ok);
    n_checks++; if (ok !== 1'b1 || err !== 1'b1 || rd !== 64'h0 || lat !== 1 || men !== 0) begin n_fail++; $display("FAIL upper_bits got ok=%b err=%b rdata=%h lat=%0d men=%0d exp 1/1/0/1/0", ok, err, rd, lat, men); end
  endtask

  task automatic test_reset_mid_access;
    bit got; int rc;
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 64'd5, 64'h0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (r0.ready) got = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL rst_mid_grant got=%b exp=1", got); end
    set_req(0, 1'b0, 1'b0, 64'h0, 64'h0);
    #1;
    n_checks++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre_en got=%b exp=1", mem_en); end
    rc = rsp_cnt;
    rst_n = 1'b0;
    set_req(0, 1'b1, 1'b0, 64'd5, 64'h0);
    set_req(1, 1'b1, 1'b0, 64'd2, 64'h0);
    @(negedge clk);
    #1;
    n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL rst_mid_en got=%b exp=0", mem_en); end
    n_checks++; if ({r0.ready, r1.ready} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_ready got=%b exp=00", {r0.ready, r1.ready}); end
    @(negedge clk);
    n_checks++; if (rsp_cnt !== rc) begin n_fail++; $display("FAIL rst_mid_no_rsp got=%0d exp=%0d", rsp_cnt - rc, 0); end
    rst_n = 1'b1;
    #1;
    n_checks++; if ({r0.ready, r1.ready} !== 2'b10) begin n_fail++; $display("FAIL rst_first_tie got=%b exp=10", {r0.ready, r1.ready}); end
    n_exp_rsp++;
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 64'h0, 64'h0);
    set_req(1, 1'b0, 1'b0, 64'h0, 64'h0);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      if (r0.rsp_valid) begin
        got = 1'b1;
        n_checks++; if (r0.rsp_rdata !== ref_read(64'd5)) begin n_fail++; $display("FAIL rst_reissue_data got=%h exp=%h", r0.rsp_rdata, ref_read(64'd5)); end
      end
      @(negedge clk);
    end
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL rst_reissue_rsp got=%b exp=1", got); end
  endtask

  task automatic test_back_to_back;
    int acc [$];
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 64'd5, 64'h0);
    for (int i = 0; i < 24; i++) begin
      #1;
      if (r0.ready) acc.push_back(cyc);
      @(negedge clk);
    end
    set_req(0, 1'b0, 1'b0, 64'h0, 64'h0);
    repeat (6) @(negedge clk);
    n_exp_rsp += acc.size();
    n_checks++; if (acc.size() !== 6) begin n_fail++; $display("FAIL b2b_count got=%0d exp=6", acc.size()); end
    for (int i = 1; i < acc.size(); i++) begin
      n_checks++; if (acc[i] - acc[i-1] !== 4) begin n_fail++; $display("FAIL b2b_gap[%0d] got=%0d exp=4", i, acc[i] - acc[i-1]); end
    end
  endtask

  task automatic test_random;
    int lat, men, port, sel, exp_lat, exp_men; logic [63:0] rd, a, d; logic err, ok, we;
    logic [64:0] exp;
    for (int n = 0; n < 40; n++) begin
      port = $urandom_range(0, 1);
      we   = 1'($urandom_range(0, 1));
      sel  = $urandom_range(0, 9);
      if (sel < 7)      a = 64'($urandom_range(0, 1023));
      else if (sel < 9) a = 64'(1024 + $urandom_range(0, 200));
      else              a = {32'($urandom_range(1, 255)), 32'($urandom_range(0, 1023))};
      d = {$urandom, $urandom};
      exp = (a >= 64'd1024) ? {1'b1, 64'h0} : (we ? {1'b0, 64'h0} : {1'b0, ref_read(a)});
      exp_q.push_back(exp);
      if (a < 64'd1024 && we) ref_mem[a] = d;
      exp_lat = exp[64] ? 1 : 3;
      exp_men = exp[64] ? 0 : 2;
      send(port, we, a, d, lat, rd, err, men, ok);
      exp = exp_q.pop_front();
      n_checks++;
      if (ok !== 1'b1 || {err, rd} !== exp || lat !== exp_lat || men !== exp_men) begin
        n_fail++;
        $display("FAIL rand[%0d] p%0d we=%b addr=%h got ok=%b err=%b rdata=%h lat=%0d men=%0d exp err=%b rdata=%h lat=%0d men=%0d",
                 n, port, we, a, ok, err, rd, lat, men, exp[64], exp[63:0], exp_lat, exp_men);
      end
    end
  endtask

  task automatic test_bus_rules;
    repeat (3) @(negedge clk);
    n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL bus_rules got=%0d violations exp=0", viol); end
    n_checks++; if (rsp_cnt !== n_exp_rsp) begin n_fail++; $display("FAIL rsp_pulses got=%0d exp=%0d", rsp_cnt, n_exp_rsp); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 1024; i++) mem_arr[i] = 64'h0;
    test_reset();
    test_write_read();
    test_tie();
    test_bounds();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    test_bus_rules();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
